// File: rtl/mem_access_mc_if.sv
// Execute-stage / data-RAM handshake bundle for the memory-access stage.
// slave  : the memory-access stage itself.
// master : whoever drives the stage (core pipeline plus RAM model).
interface mem_access_mc_if;
  // core side
  logic        Start;
  logic [31:0] Ins;
  logic [31:0] Addr;
  logic [31:0] Rdata2;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;
  logic        AlignErr;
  logic        BusErr;
  // RAM side
  logic        MemReq;
  logic        MemWE;
  logic [31:0] MemAddr;
  logic [3:0]  MemBE;
  logic [31:0] MemWdata;
  logic        MemAck;
  logic [31:0] RamData;

  modport slave (
    input  Start, Ins, Addr, Rdata2, MemAck, RamData,
    output Busy, Done, Result, AlignErr, BusErr,
           MemReq, MemWE, MemAddr, MemBE, MemWdata
  );

  modport master (
    output Start, Ins, Addr, Rdata2, MemAck, RamData,
    input  Busy, Done, Result, AlignErr, BusErr,
           MemReq, MemWE, MemAddr, MemBE, MemWdata
  );
endinterface

// File: rtl/mem_access_mc.sv
// Multi-cycle MIPS memory-access stage: byte/half/word loads and stores
// over a req/ack RAM port, with misalignment and RAM-timeout detection.
module mem_access_mc #(
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 5
) (
  input  logic           CLK,
  input  logic           RST,
  mem_access_mc_if.slave m
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  // last counter value before abort; unused when TIMEOUT == 0
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        op_q, op_d;
  logic [31:0]       addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic [31:0]       result_q, result_d;
  logic              aerr_q, aerr_d;
  logic              berr_q, berr_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [31:0]       maddr_q, maddr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wd_q, wd_d;

  // only the opcode field of the instruction matters here
  wire unused_ins = ^m.Ins[25:0];

  // lane holding the byte at offset ofs
  function automatic logic [1:0] byte_lane(input logic [1:0] ofs);
    return BIG_ENDIAN ? 2'd3 - ofs : ofs;
  endfunction

  // lower-index lane of the halfword at (even) offset ofs
  function automatic logic [1:0] half_lane(input logic [1:0] ofs);
    return BIG_ENDIAN ? 2'd2 - ofs : ofs;
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [5:0] op, input logic [1:0] ofs);
    case (op)
      OP_LH, OP_LHU, OP_SH: return ofs[0];
      OP_LW, OP_SW:         return |ofs;
      default:              return 1'b0;
    endcase
  endfunction

  // pull the addressed byte/half/word out of the RAM word and extend it
  function automatic logic [31:0] load_ext(input logic [5:0] op, input logic [1:0] ofs,
                                           input logic [31:0] w);
    logic [31:0] bsh, hsh;
    bsh = w >> {byte_lane(ofs), 3'b000};
    hsh = w >> {half_lane(ofs), 3'b000};
    case (op)
      OP_LB:   return {{24{bsh[7]}}, bsh[7:0]};
      OP_LBU:  return {24'h0, bsh[7:0]};
      OP_LH:   return {{16{hsh[15]}}, hsh[15:0]};
      OP_LHU:  return {16'h0, hsh[15:0]};
      default: return w;
    endcase
  endfunction

  wire [5:0] in_op    = m.Ins[31:26];
  wire       in_store = (in_op == OP_SB) || (in_op == OP_SH) || (in_op == OP_SW);
  wire       q_store  = (op_q == OP_SB) || (op_q == OP_SH) || (op_q == OP_SW);

  // next-state and next-output logic; every register holds by default
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = result_q;
    aerr_d   = aerr_q;
    berr_d   = berr_q;
    req_d    = req_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    be_d     = be_q;
    wd_d     = wd_q;
    case (state_q)
      IDLE: if (m.Start) begin
        op_d   = in_op;
        addr_d = m.Addr;
        cnt_d  = '0;
        if (!is_mem_op(in_op)) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = m.Addr;
          aerr_d   = 1'b0;
          berr_d   = 1'b0;
        end else if (misaligned(in_op, m.Addr[1:0])) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = '0;
          aerr_d   = 1'b1;
          berr_d   = 1'b0;
        end else begin
          state_d = REQ;
          req_d   = 1'b1;
          we_d    = in_store;
          maddr_d = {m.Addr[31:2], 2'b00};
          case (in_op)
            OP_SB: begin
              be_d = 4'b0001 << byte_lane(m.Addr[1:0]);
              wd_d = {4{m.Rdata2[7:0]}};
            end
            OP_SH: begin
              be_d = 4'b0011 << half_lane(m.Addr[1:0]);
              wd_d = {2{m.Rdata2[15:0]}};
            end
            OP_SW: begin
              be_d = 4'b1111;
              wd_d = m.Rdata2;
            end
            default: begin
              be_d = 4'b1111;
              wd_d = '0;
            end
          endcase
        end
      end
      REQ: begin
        // an ack in the final timeout cycle still completes the access
        if (m.MemAck) begin
          state_d  = DONE;
          done_d   = 1'b1;
          req_d    = 1'b0;
          result_d = q_store ? addr_q : load_ext(op_q, addr_q[1:0], m.RamData);
          aerr_d   = 1'b0;
          berr_d   = 1'b0;
        end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
          state_d  = DONE;
          done_d   = 1'b1;
          req_d    = 1'b0;
          result_d = '0;
          aerr_d   = 1'b0;
          berr_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; reset aborts any access in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      aerr_q   <= 1'b0;
      berr_q   <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= '0;
      be_q     <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      result_q <= result_d;
      aerr_q   <= aerr_d;
      berr_q   <= berr_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      be_q     <= be_d;
      wd_q     <= wd_d;
    end
  end

  assign m.Busy     = (state_q != IDLE);
  assign m.Done     = done_q;
  assign m.Result   = result_q;
  assign m.AlignErr = aerr_q;
  assign m.BusErr   = berr_q;
  assign m.MemReq   = req_q;
  assign m.MemWE    = we_q;
  assign m.MemAddr  = maddr_q;
  assign m.MemBE    = be_q;
  assign m.MemWdata = wd_q;

endmodule

// File: tb/tb_mem_access_mc.sv
// Bench for mem_access_mc: directed scenarios plus randomized ops checked
// against a byte-addressed reference model.
module tb_mem_access_mc;
  localparam bit BE      = 1'b1;
  localparam int TIMEOUT = 16;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;

  mem_access_mc_if bus();

  mem_access_mc #(.BIG_ENDIAN(BE), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .CLK(CLK), .RST(RST), .m(bus)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res;
    logic        ae, berr, mem, we;
    logic [3:0]  bem;
    logic [31:0] wd, maddr;
    int          lat, nreq;
  } exp_t;

  typedef struct {
    logic [31:0] res;
    logic        ae, berr, we;
    logic [3:0]  bem;
    logic [31:0] wd, maddr;
    int          lat, nreq;
    bit          unstable;
  } obs_t;

  // memory seen as bytes: byte at address offset k sits in lane (3-k) for big endian
  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a,
                                 input logic [31:0] rd2, input logic [31:0] ram, input int ack_at);
    exp_t e;
    int size, lane;
    bit st, sx;
    logic [31:0] v, b;
    e = '{res: 0, ae: 0, berr: 0, mem: 0, we: 0, bem: 0, wd: 0, maddr: 0, lat: 0, nreq: 0};
    size = 0; st = 0; sx = 0;
    case (op)
      6'h20: begin size = 1; sx = 1; end
      6'h24: size = 1;
      6'h21: begin size = 2; sx = 1; end
      6'h25: size = 2;
      6'h23: size = 4;
      6'h28: begin size = 1; st = 1; end
      6'h29: begin size = 2; st = 1; end
      6'h2B: begin size = 4; st = 1; end
      default: size = 0;
    endcase
    if (size == 0) begin
      e.res = a; e.lat = 1;
    end else if ((a % size) != 0) begin
      e.ae = 1; e.res = 0; e.lat = 1;
    end else begin
      e.mem = 1; e.we = st; e.maddr = a & 32'hFFFF_FFFC;
      for (int k = 0; k < size; k++) begin
        lane = BE ? 3 - ((a + k) % 4) : ((a + k) % 4);
        e.bem[lane] = 1'b1;
      end
      if (!st) e.bem = 4'hF;
      if (!st) e.wd = 0;
      else if (size == 1) e.wd = {4{rd2[7:0]}};
      else if (size == 2) e.wd = {2{rd2[15:0]}};
      else e.wd = rd2;
      if (ack_at >= 1 && ack_at <= TIMEOUT) begin
        e.nreq = ack_at; e.lat = ack_at + 1;
        if (st) e.res = a;
        else begin
          v = 0;
          for (int k = 0; k < size; k++) begin
            lane = BE ? 3 - ((a + k) % 4) : ((a + k) % 4);
            b = (ram >> (8 * lane)) & 32'hFF;
            if (BE) v = (v << 8) | b;
            else v = v | (b << (8 * k));
          end
          if (sx && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
          if (sx && size == 2 && v[15]) v = v | 32'hFFFF_0000;
          e.res = v;
        end
      end else begin
        e.nreq = TIMEOUT; e.lat = TIMEOUT + 1; e.berr = 1; e.res = 0;
      end
    end
    return e;
  endfunction

  // issue one Start and act as the RAM; ack on request cycle ack_at (0 = never)
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] rd2,
                        input logic [31:0] ram, input int ack_at, output obs_t o);
    o = '{res: 0, ae: 0, berr: 0, we: 0, bem: 0, wd: 0, maddr: 0, lat: -1, nreq: 0, unstable: 0};
    @(negedge CLK);
    bus.Start = 1'b1; bus.Ins = {op, 26'($urandom)}; bus.Addr = a; bus.Rdata2 = rd2;
    @(negedge CLK);
    bus.Start = 1'b0; bus.Addr = $urandom; bus.Rdata2 = $urandom; bus.Ins = $urandom;
    for (int c = 1; c <= 60; c++) begin
      if (bus.Done) begin
        o.lat = c; o.res = bus.Result; o.ae = bus.AlignErr; o.berr = bus.BusErr;
        break;
      end
      if (bus.MemReq) begin
        o.nreq++;
        if (o.nreq == 1) begin
          o.we = bus.MemWE; o.bem = bus.MemBE; o.wd = bus.MemWdata; o.maddr = bus.MemAddr;
        end else if (o.we !== bus.MemWE || o.bem !== bus.MemBE || o.wd !== bus.MemWdata ||
                     o.maddr !== bus.MemAddr) o.unstable = 1;
        if (o.nreq == ack_at) begin bus.MemAck = 1'b1; bus.RamData = ram; end
      end
      @(negedge CLK);
      bus.MemAck = 1'b0; bus.RamData = $urandom;
    end
  endtask

  task automatic test_reset;
    n_cmp++; if ({bus.Busy, bus.Done, bus.AlignErr, bus.BusErr, bus.MemReq, bus.MemWE} !== 6'b0) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000000",
        {bus.Busy, bus.Done, bus.AlignErr, bus.BusErr, bus.MemReq, bus.MemWE}); end
    n_cmp++; if ({bus.Result, bus.MemAddr, bus.MemWdata, bus.MemBE} !== 100'h0) begin
      n_bad++; $display("FAIL reset_data: got %h want 0",
        {bus.Result, bus.MemAddr, bus.MemWdata, bus.MemBE}); end
  endtask

  task automatic test_nonmem;
    obs_t o;
    run_op(6'h00, 32'h0000_1234, 32'h0, 32'h0, 1, o);
    n_cmp++; if (o.lat !== 1 || o.res !== 32'h0000_1234 || o.nreq !== 0 || o.ae !== 0 || o.berr !== 0) begin
      n_bad++; $display("FAIL nonmem: lat %0d res %h nreq %0d ae %b be %b want 1 00001234 0 0 0",
        o.lat, o.res, o.nreq, o.ae, o.berr); end
  endtask

  task automatic test_byte_load;
    obs_t o;
    run_op(6'h20, 32'h101, 32'h0, 32'h11F2_3344, 1, o);
    n_cmp++; if (o.lat !== 2 || o.res !== 32'hFFFF_FFF2 || o.maddr !== 32'h100 || o.we !== 0 || o.bem !== 4'hF) begin
      n_bad++; $display("FAIL lb: lat %0d res %h maddr %h we %b be %h want 2 fffffff2 100 0 f",
        o.lat, o.res, o.maddr, o.we, o.bem); end
    run_op(6'h24, 32'h101, 32'h0, 32'h11F2_3344, 1, o);
    n_cmp++; if (o.lat !== 2 || o.res !== 32'h0000_00F2) begin
      n_bad++; $display("FAIL lbu: lat %0d res %h want 2 000000f2", o.lat, o.res); end
  endtask

  task automatic test_half_store;
    obs_t o;
    run_op(6'h29, 32'h202, 32'hDEAD_BEEF, 32'h0, 3, o);
    n_cmp++; if (o.we !== 1 || o.bem !== 4'b0011 || o.wd !== 32'hBEEF_BEEF || o.maddr !== 32'h200) begin
      n_bad++; $display("FAIL sh_bus: we %b be %b wd %h maddr %h want 1 0011 beefbeef 200",
        o.we, o.bem, o.wd, o.maddr); end
    n_cmp++; if (o.nreq !== 3 || o.unstable !== 0 || o.lat !== 4 || o.res !== 32'h202) begin
      n_bad++; $display("FAIL sh_hold: nreq %0d unstable %0d lat %0d res %h want 3 0 4 202",
        o.nreq, o.unstable, o.lat, o.res); end
  endtask

  task automatic test_misalign;
    obs_t o;
    int extra;
    run_op(6'h23, 32'h006, 32'h0, 32'h0, 1, o);
    n_cmp++; if (o.lat !== 1 || o.ae !== 1 || o.res !== 0 || o.nreq !== 0) begin
      n_bad++; $display("FAIL lw_misalign: lat %0d ae %b res %h nreq %0d want 1 1 0 0",
        o.lat, o.ae, o.res, o.nreq); end
    // stage is in DONE (Busy): this Start must be dropped
    bus.Start = 1'b1; bus.Ins = {6'h23, 26'h0}; bus.Addr = 32'h10;
    @(negedge CLK); bus.Start = 1'b0;
    extra = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.Done || bus.MemReq || bus.Busy) extra++;
      @(negedge CLK);
    end
    n_cmp++; if (extra !== 0) begin
      n_bad++; $display("FAIL start_while_busy: activity cycles %0d want 0", extra); end
    n_cmp++; if (bus.AlignErr !== 1 || bus.Result !== 0) begin
      n_bad++; $display("FAIL flag_hold: ae %b res %h want 1 0", bus.AlignErr, bus.Result); end
  endtask

  task automatic test_timeout;
    obs_t o;
    run_op(6'h23, 32'h40, 32'h0, 32'hCAFE_F00D, 0, o);
    n_cmp++; if (o.nreq !== 16 || o.lat !== 17 || o.berr !== 1 || o.res !== 0) begin
      n_bad++; $display("FAIL timeout: nreq %0d lat %0d berr %b res %h want 16 17 1 0",
        o.nreq, o.lat, o.berr, o.res); end
    run_op(6'h23, 32'h40, 32'h0, 32'hCAFE_F00D, 16, o);
    n_cmp++; if (o.nreq !== 16 || o.lat !== 17 || o.berr !== 0 || o.res !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL ack_at_timeout: nreq %0d lat %0d berr %b res %h want 16 17 0 cafef00d",
        o.nreq, o.lat, o.berr, o.res); end
  endtask

  task automatic test_reset_midreq;
    obs_t o;
    exp_t e;
    int extra;
    @(negedge CLK);
    bus.Start = 1'b1; bus.Ins = {6'h23, 26'h0}; bus.Addr = 32'h10;
    @(negedge CLK); bus.Start = 1'b0;
    @(negedge CLK);
    n_cmp++; if (bus.MemReq !== 1) begin
      n_bad++; $display("FAIL midreq_setup: memreq %b want 1", bus.MemReq); end
    #2 RST = 1'b1;
    #1;
    n_cmp++; if ({bus.MemReq, bus.Busy, bus.Done} !== 3'b000) begin
      n_bad++; $display("FAIL async_reset: req/busy/done %b want 000", {bus.MemReq, bus.Busy, bus.Done}); end
    @(negedge CLK); RST = 1'b0;
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      if (bus.Done || bus.MemReq) extra++;
      @(negedge CLK);
    end
    n_cmp++; if (extra !== 0) begin
      n_bad++; $display("FAIL abort_no_done: activity cycles %0d want 0", extra); end
    run_op(6'h2B, 32'h40, 32'h1234_5678, 32'h0, 2, o);
    e = model(6'h2B, 32'h40, 32'h1234_5678, 32'h0, 2);
    n_cmp++; if (o.res !== e.res || o.lat !== e.lat || o.bem !== e.bem || o.wd !== e.wd || o.we !== 1) begin
      n_bad++; $display("FAIL sw_after_reset: res %h lat %0d be %h wd %h we %b want %h %0d %h %h 1",
        o.res, o.lat, o.bem, o.wd, o.we, e.res, e.lat, e.bem, e.wd); end
  endtask

  task automatic test_random;
    logic [5:0] ops [10] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h00, 6'h0F};
    obs_t o;
    exp_t e;
    logic [5:0] op;
    logic [31:0] a, rd2, ram;
    int ack_at;
    for (int i = 0; i < 40; i++) begin
      op = ops[$urandom_range(9)];
      a = $urandom; rd2 = $urandom; ram = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = (op == 6'h21 || op == 6'h25 || op == 6'h29) ? {a[1], 1'b0} : a[1:0];
      ack_at = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 5);
      run_op(op, a, rd2, ram, ack_at, o);
      e = model(op, a, rd2, ram, ack_at);
      n_cmp++; if (o.res !== e.res || o.ae !== e.ae || o.berr !== e.berr || o.lat !== e.lat || o.nreq !== e.nreq) begin
        n_bad++; $display("FAIL rand%0d op %h a %h: res %h ae %b berr %b lat %0d nreq %0d want %h %b %b %0d %0d",
          i, op, a, o.res, o.ae, o.berr, o.lat, o.nreq, e.res, e.ae, e.berr, e.lat, e.nreq); end
      if (e.mem) begin
        n_cmp++; if (o.we !== e.we || o.bem !== e.bem || o.wd !== e.wd || o.maddr !== e.maddr || o.unstable !== 0) begin
          n_bad++; $display("FAIL rand%0d_bus op %h a %h: we %b be %h wd %h maddr %h unstable %0d want %b %h %h %h 0",
            i, op, a, o.we, o.bem, o.wd, o.maddr, o.unstable, e.we, e.bem, e.wd, e.maddr); end
      end
    end
  endtask

  initial begin
    bus.Start = 1'b0; bus.Ins = '0; bus.Addr = '0; bus.Rdata2 = '0;
    bus.MemAck = 1'b0; bus.RamData = '0;
    @(negedge CLK); @(negedge CLK);
    test_reset;
    RST = 1'b0;
    test_nonmem;
    test_byte_load;
    test_half_store;
    test_misalign;
    test_timeout;
    test_reset_midreq;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // hard stop in case the stimulus itself stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
